seq_scan_ctrl: RTL
==================

Name: seq_scan_ctrl

Overview:
Controller that feeds parallel words to a programmable serial pattern detector and collects the results. It accepts W-bit words over a valid/ready handshake and serializes them MSB-first, one bit per cycle. An internal Moore-style matcher, with overlapping or non-overlapping mode selectable per run, checks each bit. The block counts matches and raises a sticky threshold interrupt; it sits between a word-oriented producer and the status/CSR logic.

Parameters:
W, 8, input word width (bits serialized MSB-first)
PW, 4, maximum pattern length in bits
CW, 8, match counter / threshold width

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin run; sampled only in IDLE
abort  input  1  terminate run from any state
cfg_pattern  input  PW  pattern; bit 0 = most recently received bit
cfg_len  input  $clog2(PW)+1  pattern length in bits
cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping
irq_thresh  input  CW  interrupt threshold; 0 disables irq
in_valid  input  1  word available
in_data  input  W  word
in_last  input  1  final word of run, qualified by in_valid
in_ready  output  1  high only in LOAD
busy  output  1  high in LOAD or SHIFT
match  output  1  registered 1-cycle pulse per detected pattern
match_cnt  output  CW  saturating match count for the current run
done  output  1  1-cycle pulse on normal run completion
irq  output  1  sticky threshold interrupt

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE; in_ready, busy, match, done, irq, match_cnt all 0; history and fill counter 0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE -> LOAD on start. On that edge: latch cfg_pattern, cfg_len, cfg_overlap and irq_thresh. Clear history, fill, match_cnt and irq.
- LOAD: in_ready=1. On in_valid, capture in_data and in_last, load bit counter=W, go to SHIFT. Without in_valid, stay in LOAD with no timeout.
- SHIFT: consume one bit per cycle, MSB first. History shifts left with the new bit entering at bit 0; fill saturates at PW. After the W-th bit: go to DONE if the captured last flag is set, otherwise go to LOAD.
- DONE: done=1 for exactly one cycle, then IDLE.
- Throughput: W+1 cycles per word when in_valid is held high.
- Match condition, evaluated on each consumed bit: fill (including this bit) >= len, and the low len bits of the history equal the low len bits of the pattern.
- Match outputs: match is registered and asserts the cycle after the completing bit. match_cnt updates on the same edge.
- Mode after a match: non-overlapping clears fill to 0; overlapping leaves fill unchanged.
- History is not cleared between words, so patterns may span word boundaries.
- cfg_len=0: no match ever. cfg_len>PW: treated as PW.
- match_cnt saturates at 2^CW-1, with no wrap.
- irq sets when match_cnt reaches >= irq_thresh (irq_thresh != 0). It stays set until the next start or reset.
- A match on the last bit of a run: the match pulse and done assert in the same cycle, and match_cnt is already final.
- abort:
  - Any state -> IDLE on the next edge, with no done pulse.
  - match_cnt and irq are retained; a pending match pulse is suppressed.
  - abort takes priority over start and over in_valid in the same cycle.
- start outside IDLE is ignored.
- Config inputs are ignored except on the start edge.
- Asserting rst_n low mid-run returns every output to its reset value immediately (asynchronous).

Decomposition:
- Shared package seq_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - default parameter constants for W, PW, CW;
  - mode encoding constants OVERLAP and NON_OVERLAP.
- One sub-module, seq_match_core, holds the history shift register, fill counter, length-masked compare and overlap/non-overlap reset, plus the registered match output. Inputs: bit_valid, bit, clear, cfg.
- Top level keeps the FSM, word register, bit counter, match_cnt and irq.

Test Plan:
- Non-overlap: start (pattern 4'b1010, len 4, overlap 0); word 8'hAA with last -> match pulses 4 and 8 cycles after acceptance; match_cnt=2; done 1 cycle after the 8th bit, coinciding with the 2nd match.
- Overlap: same stimulus with overlap 1 -> matches after bits 4, 6 and 8; match_cnt=3.
- Cross-word: words 8'h0A then 8'h0A (last) -> 8'h0A is MSB-first 00001010, so matches after bits 8 and 16; match_cnt=2. in_ready is low for 8 cycles between the two acceptances.
- Saturation/irq: CW=2, irq_thresh=2, overlap 1, pattern 1 (len 1), word 8'hFF -> irq sets on the 2nd match; match_cnt holds at 3.
- Abort: abort during SHIFT after 3 bits -> IDLE next cycle; no done; in_ready stays 0; match_cnt retained. A following start clears match_cnt to 0 and irq to 0.
- Reset/edge cases:
  - rst_n low mid-SHIFT -> all outputs 0 asynchronously.
  - cfg_len=0 run -> match_cnt=0.
  - start while busy -> no effect.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial scan controller.
// Contents:
//   state_e                 - controller states (IDLE, LOAD, SHIFT, DONE)
//   W_DEF, PW_DEF, CW_DEF   - default word, pattern and counter widths
//   OVERLAP, NON_OVERLAP    - encodings of cfg_overlap
package seq_pkg;

    localparam int W_DEF  = 8;
    localparam int PW_DEF = 4;
    localparam int CW_DEF = 8;

    localparam logic OVERLAP     = 1'b1;
    localparam logic NON_OVERLAP = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit-serial pattern matcher.
// Keeps a PW-bit history (newest bit at bit 0) and a saturating fill count.
// Each valid bit is compared against the low cfg_len bits of cfg_pattern.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bit_valid    - bit_in is consumed this cycle
//   bit_in       - serial data bit
//   clear        - synchronous clear of history, fill and match
//   cfg_pattern  - pattern, bit 0 = most recent bit
//   cfg_len      - pattern length; 0 never matches, >PW is treated as PW
//   cfg_overlap  - OVERLAP keeps fill after a match, NON_OVERLAP clears it
//   hit          - combinational: the bit consumed this cycle completes a match
//   match        - registered one-cycle pulse, high the cycle after hit
module seq_match_core
    import seq_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int LW = $clog2(PW) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bit_valid,
    input  logic          bit_in,
    input  logic          clear,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    output logic          hit,
    output logic          match
);

    logic [PW-1:0] hist_r;
    logic [PW-1:0] hist_next_s;
    logic [PW-1:0] mask_s;
    logic [LW-1:0] fill_r;
    logic [LW-1:0] fill_inc_s;
    logic [LW-1:0] fill_next_s;
    logic [LW-1:0] eff_len_s;
    logic          hit_s;
    logic          match_r;

    // Mask selecting the low 'len' bits of the history/pattern.
    function automatic logic [PW-1:0] len_mask(input logic [LW-1:0] len);
        logic [PW-1:0] m;
        m = '0;
        for (int i = 0; i < PW; i++) begin
            m[i] = (LW'(i) < len);
        end
        return m;
    endfunction

    // Compare the history including the incoming bit and decide the next fill.
    always_comb begin
        eff_len_s   = (cfg_len > LW'(PW)) ? LW'(PW) : cfg_len;
        mask_s      = len_mask(eff_len_s);
        hist_next_s = {hist_r[PW-2:0], bit_in};
        fill_inc_s  = (fill_r >= LW'(PW)) ? fill_r : fill_r + LW'(1);
        hit_s       = 1'b0;
        fill_next_s = fill_inc_s;
        if (bit_valid && (eff_len_s != '0) && (fill_inc_s >= eff_len_s) &&
            (((hist_next_s ^ cfg_pattern) & mask_s) == '0)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (hit_s) begin
            case (cfg_overlap)
                OVERLAP:     fill_next_s = fill_inc_s;
                NON_OVERLAP: fill_next_s = '0;
                default:     fill_next_s = '0;
            endcase
        end else begin
            fill_next_s = fill_inc_s;
        end
    end

    // History, fill and registered match pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r  <= '0;
            fill_r  <= '0;
            match_r <= 1'b0;
        end else if (clear) begin
            hist_r  <= '0;
            fill_r  <= '0;
            match_r <= 1'b0;
        end else if (bit_valid) begin
            hist_r  <= hist_next_s;
            fill_r  <= fill_next_s;
            match_r <= hit_s;
        end else begin
            match_r <= 1'b0;
        end
    end

    assign hit   = hit_s;
    assign match = match_r;

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: word-to-serial scan controller with pattern match counting.
// Accepts W-bit words on a valid/ready handshake, shifts them MSB-first into
// seq_match_core, counts matches (saturating) and raises a sticky irq.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   start, abort                     - run control (abort wins)
//   cfg_pattern/len/overlap, irq_thresh - run config, latched on start
//   in_valid, in_data, in_last, in_ready - word input handshake
//   busy, match, match_cnt, done, irq    - status outputs (all registered)
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int PW = PW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PW-1:0]        cfg_pattern,
    input  logic [$clog2(PW):0]  cfg_len,
    input  logic                 cfg_overlap,
    input  logic [CW-1:0]        irq_thresh,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 match,
    output logic [CW-1:0]        match_cnt,
    output logic                 done,
    output logic                 irq
);

    localparam int LW = $clog2(PW) + 1;
    localparam int BW = $clog2(W + 1);

    state_e          state_r;
    state_e          state_next_s;
    logic [W-1:0]    word_r;
    logic            last_r;
    logic [BW-1:0]   bit_cnt_r;
    logic [PW-1:0]   pat_r;
    logic [LW-1:0]   len_r;
    logic            ovl_r;
    logic [CW-1:0]   thr_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic            irq_r;
    logic            in_ready_r;
    logic            busy_r;
    logic            done_r;
    logic            start_go_s;
    logic            accept_s;
    logic            bit_valid_s;
    logic            clear_s;
    logic            irq_set_s;
    logic            hit_s;
    logic            match_s;

    // Next state, handshake qualifiers and match counter update.
    always_comb begin
        start_go_s   = (state_r == IDLE) && start && !abort;
        accept_s     = (state_r == LOAD) && in_valid && !abort;
        bit_valid_s  = (state_r == SHIFT) && !abort;
        clear_s      = start_go_s || abort;
        state_next_s = state_r;
        if (abort) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = start ? LOAD : IDLE;
                LOAD:    state_next_s = in_valid ? SHIFT : LOAD;
                SHIFT: begin
                    if (bit_cnt_r == BW'(1)) begin
                        state_next_s = last_r ? DONE : LOAD;
                    end else begin
                        state_next_s = SHIFT;
                    end
                end
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
        if (hit_s && (cnt_r != '1)) begin
            cnt_next_s = cnt_r + CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
        irq_set_s = (thr_r != '0) && (cnt_next_s >= thr_r);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Word register and bit counter; the word shifts left so bit W-1 is next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r    <= '0;
            last_r    <= 1'b0;
            bit_cnt_r <= '0;
        end else if (accept_s) begin
            word_r    <= in_data;
            last_r    <= in_last;
            bit_cnt_r <= BW'(W);
        end else if (bit_valid_s) begin
            word_r    <= {word_r[W-2:0], 1'b0};
            last_r    <= last_r;
            bit_cnt_r <= bit_cnt_r - BW'(1);
        end else begin
            word_r    <= word_r;
            last_r    <= last_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Run configuration, captured only when a run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r <= '0;
            len_r <= '0;
            ovl_r <= 1'b0;
            thr_r <= '0;
        end else if (start_go_s) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len;
            ovl_r <= cfg_overlap;
            thr_r <= irq_thresh;
        end else begin
            pat_r <= pat_r;
            len_r <= len_r;
            ovl_r <= ovl_r;
            thr_r <= thr_r;
        end
    end

    // Match count and sticky irq; both survive abort, cleared by a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            irq_r <= 1'b0;
        end else if (start_go_s) begin
            cnt_r <= '0;
            irq_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            irq_r <= irq_r | irq_set_s;
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_next_s == LOAD);
            busy_r     <= (state_next_s == LOAD) || (state_next_s == SHIFT);
            done_r     <= (state_next_s == DONE);
        end
    end

    seq_match_core #(
        .PW (PW),
        .LW (LW)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_valid   (bit_valid_s),
        .bit_in      (word_r[W-1]),
        .clear       (clear_s),
        .cfg_pattern (pat_r),
        .cfg_len     (len_r),
        .cfg_overlap (ovl_r),
        .hit         (hit_s),
        .match       (match_s)
    );

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign match     = match_s;
    assign match_cnt = cnt_r;
    assign done      = done_r;
    assign irq       = irq_r;

endmodule
